// File: rtl/record_serializer.sv
// record_serializer
//
// Queues fixed-width records arriving as one-cycle strobes in a small FIFO and
// emits each record MSB-first as a stream of bytes over a valid/ready interface.
// The input side cannot be stalled, so records arriving at a full FIFO are
// dropped and counted instead.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   in_data     record payload, sampled while in_valid is high
//   in_valid    single-cycle record strobe
//   tx_data     current output byte
//   tx_valid    tx_data is valid
//   tx_ready    downstream accepts tx_data this cycle
//   fifo_level  records currently stored (0..DEPTH), excluding the one being sent
//   overflow    sticky flag, set when a record is dropped
//   drop_count  number of dropped records, saturating at 255

module record_serializer #(
   parameter int unsigned AW    = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [AW-1:0]            in_data,
   input  logic                     in_valid,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int unsigned NB = AW / 8;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [LW-1:0] FullLvl = LW'(DEPTH);
   localparam logic [IW-1:0] LastIdx = IW'(NB - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [AW-1:0]    shreg_q;
   logic [IW-1:0]    idx_q;
   logic             overflow_q;
   logic [7:0]       drop_q;

   logic             pop;
   logic             xfer;
   logic             accept;
   logic             reject;

   // Event decode. A pop frees a slot in the same cycle, so a write at full
   // still lands when the reader is taking a record.
   always_comb begin
      pop    = (state_q == StIdle) && (level_q != '0);
      xfer   = (state_q == StSend) && tx_ready;
      accept = in_valid && ((level_q < FullLvl) || pop);
      reject = in_valid && !accept;
   end

   // ---------------------------------------------------------------- reader FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (level_q != '0) begin
               state_d = StSend;
            end
         end
         StSend: begin
            if (xfer && (idx_q == LastIdx)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs come straight from registered state; tx_ready only affects the
   // next state, never the current outputs.
   always_comb begin
      tx_valid = (state_q == StSend);
      tx_data  = shreg_q[AW-1 -: 8];
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q  <= '0;
         idx_q    <= '0;
         rd_ptr_q <= '0;
      end else if (pop) begin
         // Non-blocking read sees the pre-write contents if a write hits the
         // same slot this cycle.
         shreg_q  <= mem[rd_ptr_q];
         idx_q    <= '0;
         rd_ptr_q <= rd_ptr_q + PW'(1);
      end else if (xfer && (idx_q != LastIdx)) begin
         shreg_q  <= shreg_q << 8;
         idx_q    <= idx_q + IW'(1);
      end
   end

   // Storage is not reset; the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (accept) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         case ({accept, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (reject) begin
         overflow_q <= 1'b1;
         if (drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_record_serializer.sv
module tb_record_serializer;

   localparam int unsigned AW    = 48;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NB    = AW / 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic [2:0]    fifo_level;
   logic          overflow;
   logic [7:0]    drop_count;

   int vectors = 0;
   int miscompares = 0;

   record_serializer #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Record r has bytes (r+1)*16 + k, k = 0..5, MSB first.
   function automatic logic [AW-1:0] rec(input int r);
      logic [AW-1:0] v;
      for (int k = 0; k < NB; k++) begin
         v[AW-1-8*k -: 8] = 8'((r + 1) * 16 + k);
      end
      return v;
   endfunction

   // ------------------------------------------------------------------ model
   // Records waiting in the FIFO, bytes of the record in flight, and the
   // overflow bookkeeping. An empty byte queue means the reader is idle.
   logic [AW-1:0] m_q[$];
   logic [7:0]    m_cur[$];
   logic          m_ovf;
   int            m_drops;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_cur.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         logic          idle;
         logic          take;
         logic          full;
         logic [AW-1:0] r;
         idle = (m_cur.size() == 0);
         take = idle && (m_q.size() != 0);
         full = (m_q.size() == DEPTH);
         if (!idle && tx_ready) void'(m_cur.pop_front());
         if (take) begin
            r = m_q.pop_front();
            for (int k = 0; k < NB; k++) m_cur.push_back(r[AW-1-8*k -: 8]);
         end
         if (in_valid) begin
            if (!full || take) begin
               m_q.push_back(in_data);
            end else begin
               m_ovf = 1'b1;
               if (m_drops != 255) m_drops++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("tx_valid", tx_valid, m_cur.size() != 0);
         if (m_cur.size() != 0) chk("tx_data", tx_data, m_cur[0]);
         chk("fifo_level", fifo_level, m_q.size());
         chk("overflow", overflow, m_ovf);
         chk("drop_count", drop_count, m_drops);
      end
   end

   // Bytes actually transferred.
   logic [7:0] got[$];
   always @(negedge clk) begin
      if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   logic [7:0] bytes_a [6];

   initial begin
      bytes_a = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};

      // Reset state
      #2;
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_level", fifo_level, 3'd0);
      idle_cycles(3);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_level", fifo_level, 3'd0);
      chk("post_rst_drop", drop_count, 8'd0);

      // Single record, tx_ready high: valid in cycles 2..7, idle at 8
      tx_ready = 1'b1;
      step(); in_valid = 1'b1; in_data = 48'h0123456789AB;
      step(); in_valid = 1'b0;
      @(negedge clk); chk("single_c1_valid", tx_valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge clk);
         chk("single_valid", tx_valid, 1'b1);
         chk("single_byte", tx_data, bytes_a[i]);
      end
      step(); @(negedge clk); chk("single_end_valid", tx_valid, 1'b0);

      // Back-pressure: ready low for cycles 2..5
      idle_cycles(2);
      tx_ready = 1'b0;
      step(); in_valid = 1'b1; in_data = 48'h0123456789AB;
      step(); in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         chk("bp_hold_valid", tx_valid, 1'b1);
         chk("bp_hold_byte", tx_data, 8'h01);
      end
      for (int i = 0; i < 6; i++) begin
         step(); tx_ready = 1'b1;
         @(negedge clk);
         chk("bp_valid", tx_valid, 1'b1);
         chk("bp_byte", tx_data, bytes_a[i]);
      end
      step(); @(negedge clk); chk("bp_end_valid", tx_valid, 1'b0);

      // FIFO fill / order
      idle_cycles(2);
      tx_ready = 1'b0;
      for (int r = 0; r < 5; r++) begin
         step(); in_valid = 1'b1; in_data = rec(r);
      end
      step(); in_valid = 1'b0;
      @(negedge clk);
      chk("fill_level", fifo_level, 3'd4);
      chk("fill_ovf", overflow, 1'b0);
      chk("fill_head", tx_data, 8'h10);
      step(); got.delete(); tx_ready = 1'b1;
      idle_cycles(45);
      chk("fill_count", got.size(), 30);
      if (got.size() == 30) begin
         for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < NB; k++) chk("fill_order", got[r*NB+k], 8'((r+1)*16+k));
         end
      end

      // Overflow: 8 back-to-back writes with ready low
      tx_ready = 1'b0;
      for (int r = 0; r < 8; r++) begin
         step(); in_valid = 1'b1; in_data = rec(r);
         @(negedge clk);
         if (r == 5) chk("ovf_before", overflow, 1'b0);
         if (r == 6) chk("ovf_after", overflow, 1'b1);
      end
      step(); in_valid = 1'b0;
      @(negedge clk);
      chk("ovf_drops", drop_count, 8'd3);
      chk("ovf_level", fifo_level, 3'd4);
      for (int i = 0; i < 300; i++) begin
         step(); in_valid = 1'b1; in_data = rec(9);
      end
      step(); in_valid = 1'b0;
      @(negedge clk);
      chk("ovf_saturate", drop_count, 8'd255);

      // Reset in the middle of the third byte
      step(); tx_ready = 1'b1;
      step();
      step();
      chk("mid_byte3", tx_data, 8'h12);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_valid", tx_valid, 1'b0);
      chk("mid_rst_level", fifo_level, 3'd0);
      chk("mid_rst_ovf", overflow, 1'b0);
      chk("mid_rst_drop", drop_count, 8'd0);
      chk("mid_rst_data", tx_data, 8'h00);
      step(); reset = 1'b0; got.delete();
      idle_cycles(20);
      chk("post_mid_rst_quiet", got.size(), 0);

      // Write at full while the reader pops
      tx_ready = 1'b0;
      for (int r = 0; r < 5; r++) begin
         step(); in_valid = 1'b1; in_data = rec(r);
      end
      step(); in_valid = 1'b0;
      step(); got.delete(); tx_ready = 1'b1;
      idle_cycles(5);
      step(); in_valid = 1'b1; in_data = 48'hF0F1F2F3F4F5;
      @(negedge clk);
      chk("full_pop_idle", tx_valid, 1'b0);
      chk("full_pop_level0", fifo_level, 3'd4);
      step(); in_valid = 1'b0;
      @(negedge clk);
      chk("full_pop_level1", fifo_level, 3'd4);
      chk("full_pop_drop", drop_count, 8'd0);
      chk("full_pop_valid", tx_valid, 1'b1);
      idle_cycles(45);
      chk("full_pop_count", got.size(), 36);
      if (got.size() == 36) begin
         for (int k = 0; k < NB; k++) chk("full_pop_last", got[30+k], 8'(8'hF0 + k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/record_serializer.md
# record_serializer

Consumes the one-cycle record strobes produced by the LPC buffer/clock-domain stage, queues the records in a small FIFO, and emits each record as a sequence of bytes, MSB first, over a valid/ready byte interface to the UART transmitter. Overflow is counted rather than stalling, because the LPC side cannot be back-pressured.

## Interface
- AW, 48: record width in bits; must be a multiple of 8, at least 8. NB = AW/8 bytes per record.
- DEPTH, 4: FIFO depth in records; must be a power of 2, at least 2. LW = log2(DEPTH)+1.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  AW  record from the buffer stage; valid only while in_valid is high.
- in_valid  in  1  single-cycle record strobe.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts tx_data this cycle.
- fifo_level  out  LW  records currently stored, 0..DEPTH.
- overflow  out  1  sticky; a record was dropped.
- drop_count  out  8  dropped records, saturating at 255.

## Operation
- FIFO storage: register array mem[DEPTH] of AW bits. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The level counter is LW bits.
- Pop: occurs in any cycle where the reader is in IDLE and level != 0.
- Write accept: in_valid && (level < DEPTH || pop). When accepted, mem[wr_ptr] <= in_data and wr_ptr increments.
- Write reject: in_valid && level == DEPTH && !pop. The record is discarded, overflow <= 1, and drop_count increments unless it is already 255.
- Level update: +1 on accept without pop, -1 on pop without accept, unchanged when both or neither occur.
- Reader FSM, two states:
  - IDLE: tx_valid=0. If level != 0, load shreg <= mem[rd_ptr], increment rd_ptr, set idx <= 0, and go to SEND.
  - SEND: tx_valid=1 and tx_data=shreg[AW-1:AW-8]. On tx_valid && tx_ready:
    - if idx == NB-1, go to IDLE;
    - otherwise shreg <= shreg << 8 and idx <= idx + 1.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data and tx_valid hold unchanged.
  - tx_valid never drops without a transfer.
  - tx_ready may be high at any time; it has no effect in IDLE.
- Simultaneous events:
  - A write and a pop in the same cycle with level == DEPTH is accepted; level stays at DEPTH.
  - If the write and the pop use the same slot, the pop reads the old mem contents, which is the record at rd_ptr before the write.
- Reset, including mid-record: asynchronously forces the following, and discards any partially sent record:
  - state=IDLE, tx_valid=0, tx_data=0, shreg=0, idx=0;
  - pointers=0, fifo_level=0;
  - overflow=0, drop_count=0.
- overflow and drop_count clear only on reset.

## Timing
- All state updates on the rising edge of clk, except the asynchronous reset.
- Latency, empty FIFO, reader in IDLE: in_valid high in cycle N → tx_valid high from cycle N+2.
- Throughput: NB cycles per record with tx_ready held high, plus one IDLE cycle between records. A record therefore takes NB+1 cycles.
- Sustained input rate must be at most one record per NB+1 cycles. Faster bursts are absorbed up to DEPTH records plus the one being sent.
- fifo_level drops by 1 in the cycle after the pop, when the FSM enters SEND. It is not delayed until the last byte.
- Outputs are registered or decoded from registered state only. There is no combinational path from tx_ready or in_valid to any output.

## Test plan
- Reset values: assert reset mid-SEND (byte 3 of 6) → on the same edge tx_valid=0, fifo_level=0, overflow=0, drop_count=0. After release, nothing is emitted until a new in_valid.
- Single record, AW=48, tx_ready=1: in_valid with 0x0123456789AB in cycle 10 → tx_valid=1 in cycles 12–17. tx_data is 01, 23, 45, 67, 89, AB in order. tx_valid=0 in cycle 18.
- Back-pressure: same record, tx_ready=0 for cycles 12–15 and then 1 → tx_data holds 01 through cycle 15. The remaining bytes follow in cycles 16–21 with no repeats or losses.
- FIFO fill/order: hold tx_ready=0 and write records A, B, C, D, E → A loads into shreg and fifo_level=4 (B–E stored), overflow=0. Release tx_ready → output order is A, B, C, D, E, with fifo_level decrementing once per record.
- Overflow: with tx_ready=0, write 8 records → records 1–5 are kept, and overflow=1 from the cycle after the 6th write. drop_count=3. Drive 300 further rejected writes → drop_count saturates at 255.
- Write at full with simultaneous pop: fifo_level=4, reader entering IDLE, in_valid in the same cycle → write accepted, fifo_level stays 4, drop_count unchanged, and the new record is emitted last.
